// File: rtl/player_nav_pkg.sv
// Shared types and helpers for the maze player controller.
// Direction vectors, command codes and FSM states.
package player_nav_pkg;

  typedef enum logic [1:0] {
    EAST,
    NORTH,
    WEST,
    SOUTH
  } dir_t;

  typedef enum logic [2:0] {
    NONE,
    TURN_P,
    TURN_N,
    FWD,
    BACK
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } nav_state_t;

  function automatic logic signed [1:0] fwd_dx(dir_t d);
    logic signed [1:0] r;
    r = 2'sd0;
    case (d)
      EAST:    r = 2'sd1;
      WEST:    r = -2'sd1;
      default: r = 2'sd0;
    endcase
    return r;
  endfunction

  function automatic logic signed [1:0] fwd_dy(dir_t d);
    logic signed [1:0] r;
    r = 2'sd0;
    case (d)
      NORTH:   r = -2'sd1;
      SOUTH:   r = 2'sd1;
      default: r = 2'sd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/player_nav_if.sv
// Map lookup channel between the player controller and the map memory.
// Coordinates are held by the master from map_req until map_valid.
interface player_nav_if #(
  parameter int XW = 6,
  parameter int YW = 6
) ();

  logic          map_req;
  logic [XW-1:0] map_x;
  logic [YW-1:0] map_y;
  logic          map_valid;
  logic          map_wall;

  modport master (
    output map_req,
    output map_x,
    output map_y,
    input  map_valid,
    input  map_wall
  );

  modport slave (
    input  map_req,
    input  map_x,
    input  map_y,
    output map_valid,
    output map_wall
  );

endinterface

// File: rtl/player_nav_cmd_slot.sv
// Key priority encoder plus a 1-deep pending command register.
// A queued command always wins over keys arriving in the same cycle.
module player_nav_cmd_slot
  import player_nav_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] key_pressed,
  input  logic       busy,
  input  logic       accept,
  output cmd_t       cmd,
  output logic       valid
);

  cmd_t enc;
  cmd_t slot;
  logic full;

  // highest key index wins, the rest are dropped
  always_comb begin
    enc = NONE;
    if (key_pressed[3])      enc = TURN_P;
    else if (key_pressed[2]) enc = TURN_N;
    else if (key_pressed[1]) enc = FWD;
    else if (key_pressed[0]) enc = BACK;
  end

  // park one command while busy, release it when the FSM takes it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      full <= 1'b0;
      slot <= NONE;
    end else if (accept && full) begin
      full <= 1'b0;
    end else if (busy && !full && enc != NONE) begin
      full <= 1'b1;
      slot <= enc;
    end
  end

  assign cmd   = full ? slot : enc;
  assign valid = full | (!busy && enc != NONE);

endmodule

// File: rtl/player_nav.sv
// Maze player controller: turns, steps and wall collision via map lookup.
// Emits refresh on each visible change and bump on each blocked move.
module player_nav
  import player_nav_pkg::*;
#(
  parameter int MAP_W    = 11,
  parameter int MAP_H    = 21,
  parameter int XW       = 6,
  parameter int YW       = 6,
  parameter int INIT_X   = 5,
  parameter int INIT_Y   = 2,
  parameter int INIT_DIR = 3,
  parameter int TIMEOUT  = 15,
  parameter int SCW      = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [3:0]           key_pressed,
  player_nav_if.master         map,
  output logic signed [XW-1:0] px,
  output logic signed [YW-1:0] py,
  output logic [1:0]           direction,
  output logic                 refresh,
  output logic                 bump,
  output logic                 busy,
  output logic [SCW-1:0]       step_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic signed [XW:0] XMAX = (XW+1)'(MAP_W - 1);
  localparam logic signed [YW:0] YMAX = (YW+1)'(MAP_H - 1);

  nav_state_t state, state_n;
  dir_t dir, dir_n;
  logic signed [XW-1:0] px_n;
  logic signed [YW-1:0] py_n;
  logic [XW-1:0] mx, mx_n;
  logic [YW-1:0] my, my_n;
  logic [SCW-1:0] sc_n;
  logic [TW-1:0] wcnt, wcnt_n;
  logic refresh_n, bump_n;

  cmd_t cmd;
  logic cmd_valid, accept;

  logic signed [1:0] dx, dy;
  logic signed [XW:0] xs, dxe, tx;
  logic signed [YW:0] ys, dye, ty;
  logic in_bounds;

  player_nav_cmd_slot u_slot (
    .clk        (clk),
    .rstn       (rstn),
    .key_pressed(key_pressed),
    .busy       (busy),
    .accept     (accept),
    .cmd        (cmd),
    .valid      (cmd_valid)
  );

  // target square for a forward or back step, one bit wider for the sign
  always_comb begin
    dx  = fwd_dx(dir);
    dy  = fwd_dy(dir);
    xs  = {px[XW-1], px};
    ys  = {py[YW-1], py};
    dxe = {{(XW-1){dx[1]}}, dx};
    dye = {{(YW-1){dy[1]}}, dy};
    tx  = (cmd == BACK) ? xs - dxe : xs + dxe;
    ty  = (cmd == BACK) ? ys - dye : ys + dye;
    in_bounds = !tx[XW] && (tx <= XMAX) &&
                !ty[YW] && (ty <= YMAX);
  end

  // next state and next values of all registered outputs
  always_comb begin
    state_n   = state;
    dir_n     = dir;
    px_n      = px;
    py_n      = py;
    mx_n      = mx;
    my_n      = my;
    sc_n      = step_count;
    wcnt_n    = wcnt;
    refresh_n = 1'b0;
    bump_n    = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          unique case (cmd)
            TURN_P: begin
              dir_n     = dir_t'(dir + 2'd1);
              refresh_n = 1'b1;
            end
            TURN_N: begin
              dir_n     = dir_t'(dir - 2'd1);
              refresh_n = 1'b1;
            end
            FWD, BACK: begin
              if (in_bounds) begin
                mx_n    = tx[XW-1:0];
                my_n    = ty[YW-1:0];
                state_n = REQ;
              end else begin
                bump_n = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      REQ, WAIT: begin
        if (map.map_valid) begin
          state_n = DONE;
          if (map.map_wall) begin
            bump_n = 1'b1;
          end else begin
            px_n      = $signed(mx);
            py_n      = $signed(my);
            refresh_n = 1'b1;
            sc_n      = (&step_count) ? step_count
                                      : step_count + 1'b1;
          end
        end else if (state == REQ) begin
          state_n = WAIT;
          wcnt_n  = '0;
        end else if (wcnt == TW'(TIMEOUT - 1)) begin
          state_n = DONE;
          bump_n  = 1'b1;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      dir        <= dir_t'(2'(INIT_DIR));
      px         <= XW'(INIT_X);
      py         <= YW'(INIT_Y);
      mx         <= '0;
      my         <= '0;
      step_count <= '0;
      wcnt       <= '0;
      refresh    <= 1'b0;
      bump       <= 1'b0;
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      px         <= px_n;
      py         <= py_n;
      mx         <= mx_n;
      my         <= my_n;
      step_count <= sc_n;
      wcnt       <= wcnt_n;
      refresh    <= refresh_n;
      bump       <= bump_n;
    end
  end

  assign direction   = dir;
  assign busy        = (state != IDLE);
  assign map.map_req = (state == REQ);
  assign map.map_x   = mx;
  assign map.map_y   = my;

endmodule
